// File: rtl/priority_arbiter_param.sv
// N-way arbiter with run-time fixed-priority / round-robin selection and a bounded grant tenure.
// One-cycle request-to-grant latency; all outputs registered; holders switch without an idle bubble.
module priority_arbiter_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HCW'(MAX_HOLD - 1) : '0;
  localparam logic [IDW:0]   N_W       = (IDW + 1)'(N);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [HCW-1:0] hold_cnt;

  logic [N-1:0]   cand;
  logic           holder_req;
  logic           others;
  logic           tenure_ok;
  logic           keep;
  logic           load;
  logic [N-1:0]   rot;
  logic [IDW-1:0] fp_idx;
  logic [IDW-1:0] rr_off;
  logic [IDW:0]   rr_sum;
  logic [IDW-1:0] rr_idx;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] rr_next;
  logic [N-1:0]   win_onehot;

  function automatic logic [IDW-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDW'(i);
    end
  endfunction

  // The current holder is always masked out of the candidates: on a voluntary
  // release its request bit is already 0, on a forced release it must lose.
  always_comb begin
    cand       = req & ~grant;
    holder_req = |(req & grant);
    others     = |cand;
    tenure_ok  = (MAX_HOLD == 0) || (hold_cnt < HOLD_LAST);
    keep       = (state == GRANT) && holder_req && (!others || tenure_ok);
    load       = !keep && others;
  end

  // Round-robin: rotate the candidates so rr_ptr lands on bit 0, pick the lowest, rotate back.
  always_comb begin
    rot     = N'({cand, cand} >> rr_ptr);
    fp_idx  = lowest_set(cand);
    rr_off  = lowest_set(rot);
    rr_sum  = {1'b0, rr_ptr} + {1'b0, rr_off};
    rr_idx  = (rr_sum >= N_W) ? IDW'(rr_sum - N_W) : rr_sum[IDW-1:0];
    win_idx = mode ? rr_idx : fp_idx;
    rr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else if (keep) begin
      if (hold_cnt < HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
    end else if (load) begin
      state       <= GRANT;
      rr_ptr      <= rr_next;
      hold_cnt    <= '0;
      grant       <= win_onehot;
      grant_valid <= 1'b1;
      grant_id    <= win_idx;
    end else begin
      state       <= IDLE;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end
  end

endmodule

// File: tb/tb_priority_arbiter_param.sv
// Bench for priority_arbiter_param: directed scenarios against fixed expectations,
// plus a randomized sweep checked against a holder/tenure reference model.
module tb_priority_arbiter_param;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic           mode;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  int n_checks;
  int n_fail;

  // reference model: who holds, for how many cycles so far, and the rotation start
  int           m_holder;
  int           m_held;
  int           m_ptr;
  logic [N-1:0] exp_grant;

  priority_arbiter_param #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .mode       (mode),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] c, input logic m, input int p);
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = m ? (p + k) % N : k;
      if (w < 0 && c[j]) w = j;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_holder  = -1;
    m_held    = 0;
    m_ptr     = 0;
    exp_grant = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic m);
    logic [N-1:0] c;
    c = r;
    if (m_holder >= 0) c[m_holder] = 1'b0;
    if (m_holder >= 0 && r[m_holder] && (c == '0 || m_held < MAX_HOLD)) begin
      m_held++;
    end else if (c == '0) begin
      m_holder = -1;
      m_held   = 0;
    end else begin
      m_holder = pick(c, m, m_ptr);
      m_held   = 1;
      m_ptr    = (m_holder + 1) % N;
    end
    exp_grant = '0;
    if (m_holder >= 0) exp_grant[m_holder] = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req   = '0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: grant=%b valid=%b, required 0000/0", grant, grant_valid);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = '0;
    mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b valid=%b id=%0d, required 0000/0/0", grant, grant_valid, grant_id);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: grant=%b valid=%b id=%0d, required 0000/0/0", grant, grant_valid, grant_id);
    end
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_grant: grant=%b valid=%b, required 0001/1", grant, grant_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: grant=%b valid=%b id=%0d, required 0000/0/0", grant, grant_valid, grant_id);
    end
    @(negedge clk);
    req   = '0;
    reset = 1'b1;
  endtask

  task automatic test_fixed();
    pulse_reset();
    @(negedge clk);
    mode = 1'b0;
    req  = 4'b1010;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_first: grant=%b id=%0d valid=%b, required 0010/1/1", grant, grant_id, grant_valid);
    end
    @(negedge clk);
    req = 4'b1000;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_switch: grant=%b id=%0d valid=%b, required 1000/3/1", grant, grant_id, grant_valid);
    end
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL fixed_idle: grant=%b valid=%b id=%0d, required 0000/0/0", grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_tenure_fixed();
    logic [N-1:0] exp;
    pulse_reset();
    @(negedge clk);
    mode = 1'b0;
    req  = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      exp = (((c / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      n_checks++;
      if (grant !== exp) begin
        n_fail++;
        $display("FAIL tenure_fixed cycle %0d: grant=%b, required %b", c, grant, exp);
      end
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    pulse_reset();
    @(negedge clk);
    mode = 1'b1;
    req  = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      exp = '0;
      exp[c / 4] = 1'b1;
      n_checks++;
      if (grant !== exp || grant_id !== IDW'(c / 4)) begin
        n_fail++;
        $display("FAIL rr_rotate cycle %0d: grant=%b id=%0d, required %b id=%0d", c, grant, grant_id, exp, c / 4);
      end
    end
    pulse_reset();
    @(negedge clk);
    req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      exp = (c < 4) ? 4'b0001 : 4'b0100;
      n_checks++;
      if (grant !== exp) begin
        n_fail++;
        $display("FAIL rr_sparse cycle %0d: grant=%b, required %b", c, grant, exp);
      end
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_lone_holder();
    pulse_reset();
    @(negedge clk);
    mode = 1'b0;
    req  = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (grant !== 4'b0100 || grant_id !== 2'd2) begin
        n_fail++;
        $display("FAIL lone_holder cycle %0d: grant=%b id=%0d, required 0100 id=2", c, grant, grant_id);
      end
      @(negedge clk);
      if (c >= 3) mode = ~mode;
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] cur;
    logic [N-1:0] sampled;
    logic [IDW-1:0] exp_id;
    int wait_cnt [N];
    for (int m = 0; m < 2; m++) begin
      for (int rep = 0; rep < 6; rep++) begin
        pulse_reset();
        cur = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
          @(negedge clk);
          mode = m[0];
          if ($urandom_range(0, 4) == 0) begin
            cur = N'($urandom);
          end else begin
            for (int i = 0; i < N; i++) begin
              if (cur[i]) begin
                if (exp_grant[i] && $urandom_range(0, 2) == 0) cur[i] = 1'b0;
              end else if ($urandom_range(0, 1) == 1) begin
                cur[i] = 1'b1;
              end
            end
          end
          req     = cur;
          sampled = cur;
          model_step(cur, m[0]);
          exp_id  = (m_holder >= 0) ? IDW'(m_holder) : '0;
          @(posedge clk); #1;
          n_checks++;
          if (grant !== exp_grant || grant_id !== exp_id || grant_valid !== (exp_grant != '0)) begin
            n_fail++;
            $display("FAIL rand_model mode=%0d req=%b: grant=%b id=%0d valid=%b, required %b id=%0d", m, sampled, grant, grant_id, grant_valid, exp_grant, exp_id);
          end
          n_checks++;
          if (!$onehot0(grant)) begin
            n_fail++;
            $display("FAIL rand_onehot: grant=%b, required one-hot or zero", grant);
          end
          n_checks++;
          if (grant_valid ? (grant !== (4'b0001 << grant_id)) : (grant_id !== '0 || grant !== '0)) begin
            n_fail++;
            $display("FAIL rand_id_consistency: grant=%b id=%0d valid=%b, required matching", grant, grant_id, grant_valid);
          end
          n_checks++;
          if ((grant & ~sampled) !== '0) begin
            n_fail++;
            $display("FAIL rand_granted_requested: grant=%b req=%b, required grant within req", grant, sampled);
          end
          for (int i = 0; i < N; i++) begin
            wait_cnt[i] = (sampled[i] && !grant[i]) ? wait_cnt[i] + 1 : 0;
            if (m == 1) begin
              n_checks++;
              if (wait_cnt[i] > (N - 1) * MAX_HOLD + 1) begin
                n_fail++;
                $display("FAIL rand_starvation requester %0d: waited %0d, required <= %0d", i, wait_cnt[i], (N - 1) * MAX_HOLD + 1);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_fixed();
    test_tenure_fixed();
    test_round_robin();
    test_lone_holder();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
